// File: rtl/midi_uart_rx.sv
// -----------------------------------------------------------------------------
// midi_uart_rx
//
// Serial MIDI front end. Receives 8N1 bytes from the opto-isolated MIDI input
// and tracks running status. Each channel or system-common byte is presented
// as a (byteready, cur_status, midi_bytes, databyte) tuple. Real-time bytes
// (F8..FF) go out on a separate strobe and never touch the tuple.
//
// Ports:
//   clock_25     in   system clock
//   iRST_N       in   asynchronous active-low reset
//   midi_rxd     in   raw serial line, idle high, asynchronous to clock_25
//   byteready    out  high for READY_CYCLES clocks per forwarded byte;
//                     consumers sample the tuple on its falling edge
//   cur_status   out  current running status byte
//   midi_bytes   out  position of databyte in the message (0 = status byte)
//   databyte     out  last forwarded byte (status or data)
//   rt_strobe    out  one-clock pulse per received real-time byte
//   rt_byte      out  last real-time byte received
//   frame_error  out  one-clock pulse when the stop bit is sampled low
// -----------------------------------------------------------------------------
module midi_uart_rx #(
  parameter int CLK_HZ       = 25000000,
  parameter int BAUD         = 31250,
  parameter int READY_CYCLES = 4
) (
  input  logic       clock_25,
  input  logic       iRST_N,
  input  logic       midi_rxd,
  output logic       byteready,
  output logic [7:0] cur_status,
  output logic [7:0] midi_bytes,
  output logic [7:0] databyte,
  output logic       rt_strobe,
  output logic [7:0] rt_byte,
  output logic       frame_error
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] FULL_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]       READY_LAST = 4'(READY_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } rx_state_e;

  // Number of data bytes that follow a status byte.
  typedef enum logic [1:0] {
    LEN_0,
    LEN_1,
    LEN_2,
    LEN_SYSEX
  } msg_len_e;

  function automatic msg_len_e status_len(input logic [7:0] s);
    msg_len_e len;
    len = LEN_0;
    case (s[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = LEN_2;
      4'hC, 4'hD:                   len = LEN_1;
      4'hF: begin
        case (s[3:0])
          4'h0:       len = LEN_SYSEX;
          4'h1, 4'h3: len = LEN_1;
          4'h2:       len = LEN_2;
          default:    len = LEN_0;   // F4..F7 carry no data
        endcase
      end
      default: len = LEN_0;
    endcase
    return len;
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronizer. Both flops reset to the idle (high) level so that
  // leaving reset never looks like a start bit.
  // ---------------------------------------------------------------------------
  logic rxd_meta;
  logic rxd_sync;

  // NOTE: clocked state always uses non-blocking (<=) assignments so every
  // flop samples the pre-edge value of its inputs, independent of block order.
  always_ff @(posedge clock_25 or negedge iRST_N) begin
    if (!iRST_N) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= midi_rxd;
      rxd_sync <= rxd_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  rx_state_e        state, state_n;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift_reg, shift_reg_n;
  logic             byte_done;
  logic             stop_low;

  always_ff @(posedge clock_25 or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= S_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_n;
      clk_cnt   <= clk_cnt_n;
      bit_idx   <= bit_idx_n;
      shift_reg <= shift_reg_n;
    end
  end

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_n     = state;
    clk_cnt_n   = clk_cnt;
    bit_idx_n   = bit_idx;
    shift_reg_n = shift_reg;
    byte_done   = 1'b0;
    stop_low    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (!rxd_sync) begin
          state_n   = S_START;
          clk_cnt_n = '0;
          bit_idx_n = '0;
        end
      end

      // Re-check the line half a bit in; a short low pulse is a glitch.
      S_START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_n = '0;
          state_n   = rxd_sync ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end

      // From the start-bit centre, each full bit period lands on a bit centre.
      S_DATA: begin
        if (clk_cnt == FULL_LAST) begin
          clk_cnt_n   = '0;
          shift_reg_n = {rxd_sync, shift_reg[7:1]};   // LSB first
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (clk_cnt == FULL_LAST) begin
          clk_cnt_n = '0;
          if (rxd_sync) begin
            byte_done = 1'b1;
            state_n   = S_IDLE;
          end else begin
            stop_low  = 1'b1;
            state_n   = S_WAIT_IDLE;
          end
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end

      // A low stop bit may be a break; wait for the line to return high.
      S_WAIT_IDLE: begin
        if (rxd_sync) state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Byte classification and running-status tracking. Decided combinationally
  // in the stop-sample cycle so the registered outputs change one clock later.
  // ---------------------------------------------------------------------------
  logic       status_valid, status_valid_n;
  msg_len_e   msg_len, msg_len_n;
  logic [7:0] cur_status_n;
  logic [7:0] midi_bytes_n;
  logic       is_rt;
  logic       forward;
  logic [3:0] ready_cnt;

  always_comb begin
    status_valid_n = status_valid;
    msg_len_n      = msg_len;
    cur_status_n   = cur_status;
    midi_bytes_n   = midi_bytes;
    forward        = 1'b0;
    is_rt          = byte_done && (shift_reg >= 8'hF8);

    if (byte_done && !is_rt) begin
      if (shift_reg[7]) begin
        // Status byte, including F7. Statuses with no data (F4..F7) leave
        // running status invalid so later data bytes are dropped.
        forward        = 1'b1;
        cur_status_n   = shift_reg;
        midi_bytes_n   = 8'd0;
        msg_len_n      = status_len(shift_reg);
        status_valid_n = (status_len(shift_reg) != LEN_0);
      end else if (status_valid) begin
        forward = 1'b1;
        unique case (msg_len)
          LEN_1: begin
            midi_bytes_n = 8'd1;
            if (cur_status == 8'hF1 || cur_status == 8'hF3) status_valid_n = 1'b0;
          end
          LEN_2: begin
            midi_bytes_n = (midi_bytes == 8'd1) ? 8'd2 : 8'd1;
            if (cur_status == 8'hF2 && midi_bytes == 8'd1) status_valid_n = 1'b0;
          end
          LEN_SYSEX: begin
            midi_bytes_n = (midi_bytes == 8'hFF) ? 8'hFF : midi_bytes + 8'd1;
          end
          default: forward = 1'b0;   // LEN_0 is never left valid
        endcase
      end
    end
  end

  always_ff @(posedge clock_25 or negedge iRST_N) begin
    if (!iRST_N) begin
      status_valid <= 1'b0;
      msg_len      <= LEN_0;
      cur_status   <= 8'h00;
      midi_bytes   <= 8'h00;
      databyte     <= 8'h00;
      byteready    <= 1'b0;
      ready_cnt    <= 4'd0;
      rt_strobe    <= 1'b0;
      rt_byte      <= 8'h00;
      frame_error  <= 1'b0;
    end else begin
      status_valid <= status_valid_n;
      msg_len      <= msg_len_n;
      cur_status   <= cur_status_n;
      rt_strobe    <= is_rt;
      frame_error  <= stop_low;
      if (is_rt) rt_byte <= shift_reg;

      // byteready: set on forward, then held for READY_CYCLES clocks total.
      if (forward) begin
        midi_bytes <= midi_bytes_n;
        databyte   <= shift_reg;
        byteready  <= 1'b1;
        ready_cnt  <= READY_LAST;
      end else if (ready_cnt != 4'd0) begin
        ready_cnt <= ready_cnt - 4'd1;
      end else begin
        byteready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_midi_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_midi_uart_rx
//
// Self-checking bench for midi_uart_rx. Runs at 64 clocks per bit to keep the
// run short; the glitch test scales its pulse to a quarter bit accordingly.
// Directed scenarios compare against hand-derived tuples; a randomized byte
// stream is compared against a message-level reference model.
// -----------------------------------------------------------------------------
module tb_midi_uart_rx;

  localparam int CLK_HZ = 2000000;
  localparam int BAUD   = 31250;
  localparam int BIT    = CLK_HZ / BAUD;   // 64
  localparam int READY  = 4;

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic       byteready;
  logic [7:0] cur_status;
  logic [7:0] midi_bytes;
  logic [7:0] databyte;
  logic       rt_strobe;
  logic [7:0] rt_byte;
  logic       frame_error;

  midi_uart_rx #(
    .CLK_HZ      (CLK_HZ),
    .BAUD        (BAUD),
    .READY_CYCLES(READY)
  ) dut (
    .clock_25   (clk),
    .iRST_N     (rst_n),
    .midi_rxd   (rxd),
    .byteready  (byteready),
    .cur_status (cur_status),
    .midi_bytes (midi_bytes),
    .databyte   (databyte),
    .rt_strobe  (rt_strobe),
    .rt_byte    (rt_byte),
    .frame_error(frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Monitor: records each byteready pulse (tuple at rise, tuple on its last
  // high cycle, width, rise cycle), each real-time strobe cycle and each
  // frame_error cycle.
  // ---------------------------------------------------------------------------
  logic [23:0] tuple;
  assign tuple = {cur_status, midi_bytes, databyte};

  logic [23:0] obs_q[$];
  logic [23:0] hold_q[$];
  int          wid_q[$];
  int unsigned rise_q[$];
  logic [7:0]  rt_q[$];
  int          fe_cycles;
  int unsigned start_q[$];

  logic        br_prev = 1'b0;
  int          cur_w;
  logic [23:0] last_tuple;

  always @(negedge clk) begin
    if (byteready) begin
      if (!br_prev) begin
        obs_q.push_back(tuple);
        rise_q.push_back(cyc);
        cur_w = 1;
      end else begin
        cur_w++;
      end
      last_tuple = tuple;
    end else if (br_prev) begin
      wid_q.push_back(cur_w);
      hold_q.push_back(last_tuple);
    end
    br_prev = byteready;
    if (rt_strobe) rt_q.push_back(rt_byte);
    if (frame_error) fe_cycles++;
  end

  // ---------------------------------------------------------------------------
  // Reference model: message-level running-status rules in plain integers.
  // ---------------------------------------------------------------------------
  logic [23:0] exp_q[$];
  logic [7:0]  exp_rt_q[$];
  int          m_status;
  bit          m_valid;
  int          m_pos;

  // Data bytes following a status: 2, 1, 0, or -1 for unbounded (sysex).
  function automatic int data_len(input int s);
    if (s >= 'h80 && s <= 'hBF) return 2;
    if (s >= 'hC0 && s <= 'hDF) return 1;
    if (s >= 'hE0 && s <= 'hEF) return 2;
    if (s == 'hF0) return -1;
    if (s == 'hF1 || s == 'hF3) return 1;
    if (s == 'hF2) return 2;
    return 0;
  endfunction

  function automatic void model_reset();
    m_status = 0;
    m_valid  = 0;
    m_pos    = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int len;
    if (b >= 8'hF8) begin
      exp_rt_q.push_back(b);
    end else if (b >= 8'h80) begin
      m_status = b;
      m_pos    = 0;
      m_valid  = (data_len(b) != 0);
      exp_q.push_back({b, 8'h00, b});
    end else if (m_valid) begin
      len = data_len(m_status);
      if (len < 0) begin
        m_pos = (m_pos < 255) ? m_pos + 1 : 255;
      end else if (len == 1) begin
        m_pos = 1;
        if (m_status >= 'hF0) m_valid = 0;
      end else begin
        m_pos = (m_pos == 1) ? 2 : 1;
        if (m_status == 'hF2 && m_pos == 2) m_valid = 0;
      end
      exp_q.push_back({8'(m_status), 8'(m_pos), b});
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no checking here)
  // ---------------------------------------------------------------------------
  task automatic clear_obs();
    obs_q.delete();
    hold_q.delete();
    wid_q.delete();
    rise_q.delete();
    rt_q.delete();
    start_q.delete();
    exp_q.delete();
    exp_rt_q.delete();
    fe_cycles = 0;
  endtask

  // One 8N1 frame plus one idle bit. A low stop bit yields a discarded byte,
  // so the model only sees properly framed bytes.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rxd = 1'b0;
    start_q.push_back(cyc);
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (BIT) @(negedge clk);
    rxd = 1'b1;
    repeat (BIT) @(negedge clk);
    if (stop_bit) model_byte(b);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    model_reset();
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    rxd   = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    checks++;
    if ({byteready, cur_status, midi_bytes, databyte, rt_strobe, rt_byte, frame_error} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got br=%b st=%h mb=%h db=%h rts=%b rtb=%h fe=%b want all zero",
               byteready, cur_status, midi_bytes, databyte, rt_strobe, rt_byte, frame_error);
    end
    rst_n = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    checks++;
    if ({byteready, cur_status, midi_bytes, databyte, rt_strobe, rt_byte, frame_error} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: got br=%b st=%h mb=%h db=%h fe=%b want all zero",
               byteready, cur_status, midi_bytes, databyte, frame_error);
    end
  endtask

  task automatic test_note_on();
    logic [23:0] want[3];
    int          lat;
    want = '{24'h90_00_90, 24'h90_01_3C, 24'h90_02_64};
    clear_obs();
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h64, 1'b1);
    checks++;
    if (obs_q.size() != 3) begin
      errors++; $display("FAIL note_on_count: got %0d pulses want 3", obs_q.size());
    end
    for (int i = 0; i < 3 && i < wid_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== want[i]) begin
        errors++; $display("FAIL note_on_tuple[%0d]: got %h want %h", i, obs_q[i], want[i]);
      end
      checks++;
      if (hold_q[i] !== want[i]) begin
        errors++; $display("FAIL note_on_stable[%0d]: got %h want %h", i, hold_q[i], want[i]);
      end
      checks++;
      if (wid_q[i] != READY) begin
        errors++; $display("FAIL note_on_width[%0d]: got %0d want %0d", i, wid_q[i], READY);
      end
    end
    // Rise must follow the stop-bit centre (9.5 bits) by a few sync clocks.
    if (rise_q.size() > 0) begin
      lat = int'(rise_q[0] - start_q[0]);
      checks++;
      if (lat < (19 * BIT) / 2 || lat > (19 * BIT) / 2 + 8) begin
        errors++; $display("FAIL note_on_latency: got %0d clocks want %0d..%0d",
                           lat, (19 * BIT) / 2, (19 * BIT) / 2 + 8);
      end
    end
  endtask

  task automatic test_running_status();
    logic [23:0] want[2];
    want = '{24'h90_01_40, 24'h90_02_00};
    clear_obs();
    send_byte(8'h40, 1'b1);
    send_byte(8'h00, 1'b1);
    checks++;
    if (obs_q.size() != 2) begin
      errors++; $display("FAIL running_count: got %0d pulses want 2", obs_q.size());
    end
    for (int i = 0; i < 2 && i < wid_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== want[i]) begin
        errors++; $display("FAIL running_tuple[%0d]: got %h want %h", i, obs_q[i], want[i]);
      end
    end
  endtask

  task automatic test_realtime();
    logic [23:0] want[3];
    want = '{24'h90_00_90, 24'h90_01_3C, 24'h90_02_64};
    clear_obs();
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'hF8, 1'b1);
    send_byte(8'h64, 1'b1);
    checks++;
    if (obs_q.size() != 3) begin
      errors++; $display("FAIL rt_tuple_count: got %0d pulses want 3", obs_q.size());
    end
    for (int i = 0; i < 3 && i < wid_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== want[i]) begin
        errors++; $display("FAIL rt_tuple[%0d]: got %h want %h", i, obs_q[i], want[i]);
      end
    end
    checks++;
    if (rt_q.size() != 1) begin
      errors++; $display("FAIL rt_strobe_cycles: got %0d want 1", rt_q.size());
    end else begin
      checks++;
      if (rt_q[0] !== 8'hF8) begin
        errors++; $display("FAIL rt_byte_at_strobe: got %h want f8", rt_q[0]);
      end
    end
    checks++;
    if (rt_byte !== 8'hF8) begin
      errors++; $display("FAIL rt_byte_held: got %h want f8", rt_byte);
    end
  endtask

  task automatic test_sysex();
    logic [23:0] want[6];
    logic [7:0]  seq[7];
    want = '{24'hF0_00_F0, 24'hF0_01_43, 24'hF0_02_10, 24'hF0_03_4C,
             24'hF0_04_7F, 24'hF7_00_F7};
    seq  = '{8'hF0, 8'h43, 8'h10, 8'h4C, 8'h7F, 8'hF7, 8'h12};
    clear_obs();
    for (int i = 0; i < 7; i++) send_byte(seq[i], 1'b1);
    // The trailing 12 follows F7 and must not be forwarded.
    checks++;
    if (obs_q.size() != 6) begin
      errors++; $display("FAIL sysex_count: got %0d pulses want 6", obs_q.size());
    end
    for (int i = 0; i < 6 && i < wid_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== want[i]) begin
        errors++; $display("FAIL sysex_tuple[%0d]: got %h want %h", i, obs_q[i], want[i]);
      end
    end
  endtask

  task automatic test_framing();
    logic [23:0] want[3];
    want = '{24'hC5_00_C5, 24'hC5_01_07, 24'hC5_01_08};
    clear_obs();
    send_byte(8'h55, 1'b0);
    checks++;
    if (fe_cycles != 1) begin
      errors++; $display("FAIL frame_error_pulse: got %0d cycles want 1", fe_cycles);
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL frame_no_forward: got %0d pulses want 0", obs_q.size());
    end
    // Short low glitch on an idle line: quarter of a bit, under the half-bit check.
    @(negedge clk);
    rxd = 1'b0;
    repeat (BIT / 4) @(negedge clk);
    rxd = 1'b1;
    repeat (12 * BIT) @(negedge clk);
    checks++;
    if (obs_q.size() != 0 || fe_cycles != 1 || rt_q.size() != 0) begin
      errors++; $display("FAIL glitch_quiet: got pulses=%0d fe=%0d rt=%0d want 0 1 0",
                         obs_q.size(), fe_cycles, rt_q.size());
    end
    send_byte(8'hC5, 1'b1);
    send_byte(8'h07, 1'b1);
    send_byte(8'h08, 1'b1);
    checks++;
    if (obs_q.size() != 3) begin
      errors++; $display("FAIL chan_pressure_count: got %0d pulses want 3", obs_q.size());
    end
    for (int i = 0; i < 3 && i < wid_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== want[i]) begin
        errors++; $display("FAIL chan_pressure_tuple[%0d]: got %h want %h", i, obs_q[i], want[i]);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] b;
    logic [23:0] want[2];
    want = '{24'h80_00_80, 24'h80_01_3C};
    b = 8'h3C;
    clear_obs();
    send_byte(8'h90, 1'b1);
    // Partial frame; reset lands in the middle of bit 4.
    @(negedge clk);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = b[4];
    repeat (BIT / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({byteready, cur_status, midi_bytes, databyte, rt_strobe, rt_byte, frame_error} !== '0) begin
      errors++;
      $display("FAIL abort_reset_outputs: got br=%b st=%h mb=%h db=%h rtb=%h fe=%b want all zero",
               byteready, cur_status, midi_bytes, databyte, rt_byte, frame_error);
    end
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (12 * BIT) @(negedge clk);
    checks++;
    if (obs_q.size() != 1 || fe_cycles != 0) begin
      errors++; $display("FAIL abort_no_partial: got pulses=%0d fe=%0d want 1 0",
                         obs_q.size(), fe_cycles);
    end
    clear_obs();
    send_byte(8'h80, 1'b1);
    send_byte(8'h3C, 1'b1);
    checks++;
    if (obs_q.size() != 2) begin
      errors++; $display("FAIL after_abort_count: got %0d pulses want 2", obs_q.size());
    end
    for (int i = 0; i < 2 && i < wid_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== want[i]) begin
        errors++; $display("FAIL after_abort_tuple[%0d]: got %h want %h", i, obs_q[i], want[i]);
      end
    end
  endtask

  task automatic test_random_stream();
    logic [7:0] b;
    int         r;
    apply_reset();
    clear_obs();
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 4 || r == 9) b = 8'($urandom_range(0, 127));
      else if (r <= 6)      b = 8'($urandom_range(128, 239));
      else if (r == 7)      b = 8'($urandom_range(240, 247));
      else                  b = 8'($urandom_range(248, 255));
      send_byte(b, 1'b1);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL random_count: got %0d pulses want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wid_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || hold_q[i] !== exp_q[i] || wid_q[i] != READY) begin
        errors++; $display("FAIL random_tuple[%0d]: got %h/%h width %0d want %h width %0d",
                           i, obs_q[i], hold_q[i], wid_q[i], exp_q[i], READY);
      end
    end
    checks++;
    if (rt_q.size() != exp_rt_q.size()) begin
      errors++; $display("FAIL random_rt_count: got %0d want %0d", rt_q.size(), exp_rt_q.size());
    end
    for (int i = 0; i < exp_rt_q.size() && i < rt_q.size(); i++) begin
      checks++;
      if (rt_q[i] !== exp_rt_q[i]) begin
        errors++; $display("FAIL random_rt[%0d]: got %h want %h", i, rt_q[i], exp_rt_q[i]);
      end
    end
    checks++;
    if (fe_cycles != 0) begin
      errors++; $display("FAIL random_frame_error: got %0d cycles want 0", fe_cycles);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rxd   = 1'b1;
    test_reset();
    test_note_on();
    test_running_status();
    test_realtime();
    test_sysex();
    test_framing();
    test_reset_abort();
    test_random_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
